// File: rtl/conv_seq_pkg.sv
// Shared types and defaults for the multi-layer convolution sequencer.
package conv_seq_pkg;

  localparam int DEF_MAX_LAYERS     = 8;
  localparam int DEF_LAYER_W        = 3;
  localparam int DEF_TIMEOUT_CYCLES = 65536;

  // Ping-pong encoding: which buffer the accelerator reads this layer.
  localparam logic BUF_A_IN = 1'b0;
  localparam logic BUF_B_IN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_NEXT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/conv_seq_watchdog.sv
// Per-layer watchdog counter. Held at zero while clear is high, counts while
// enable is high, and flags expiry on the last allowed cycle.
module conv_seq_watchdog
  import conv_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST_CNT);
  assign expired   = enable && w_at_last;

  // Cycle counter; saturates at the limit so it never wraps.
  // NOTE: state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !w_at_last) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Multi-layer scheduler in front of conv_accelerator: launches one
// accelerator run per layer, ping-pongs the buffer select between layers and
// pulses done when the stack completes.
// Optional feature macro: CONV_SEQ_WATCHDOG_EN (per-layer hang watchdog).
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int MAX_LAYERS     = DEF_MAX_LAYERS,
  parameter int LAYER_W        = DEF_LAYER_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LAYER_W:0]   num_layers,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               buf_sel,
  output logic               acc_start,
  input  logic               acc_busy,
  input  logic               acc_done
);

  localparam logic [LAYER_W:0] MAX_N = (LAYER_W + 1)'(MAX_LAYERS);

  // Elaboration-time parameter sanity.
  if (LAYER_W < $clog2(MAX_LAYERS)) begin : g_bad_layer_w
    $error("LAYER_W too narrow for MAX_LAYERS");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t             r_state;
  logic [LAYER_W:0]   r_num_layers;
  logic [LAYER_W-1:0] r_layer_idx;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_buf_sel;
  logic               r_acc_start;
  logic               w_expired;
  logic               w_last_layer;

`ifdef CONV_SEQ_WATCHDOG_EN
  conv_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (r_state != ST_RUN),
    .enable (r_state == ST_RUN),
    .expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  assign w_last_layer = ({1'b0, r_layer_idx} == (r_num_layers - (LAYER_W + 1)'(1)));

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_num_layers <= '0;
      r_layer_idx  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_buf_sel    <= BUF_A_IN;
      r_acc_start  <= 1'b0;
    end else if (abort) begin
      // Abort outranks start and acc_done; layer_idx/buf_sel/error are kept.
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_acc_start <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_acc_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_layers <= (num_layers > MAX_N) ? MAX_N : num_layers;
            r_layer_idx  <= '0;
            r_buf_sel    <= BUF_A_IN;
            r_error      <= 1'b0;
            r_busy       <= 1'b1;
            if (num_layers == '0) begin
              r_state <= ST_FINISH;
            end else begin
              r_state     <= ST_LAUNCH;
              r_acc_start <= !acc_busy;
            end
          end
        end
        ST_LAUNCH: begin
          // A visible acc_start means the launch is done; else keep polling.
          if (r_acc_start) begin
            r_state <= ST_RUN;
          end else begin
            r_acc_start <= !acc_busy;
          end
        end
        ST_RUN: begin
          if (acc_done) begin
            r_state <= ST_NEXT;
          end else if (w_expired) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end
        end
        ST_NEXT: begin
          if (w_last_layer) begin
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_layer_idx <= r_layer_idx + LAYER_W'(1);
            r_buf_sel   <= ~r_buf_sel;
            r_acc_start <= !acc_busy;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_FINISH: begin
          // Entered with done already set (normal/timeout) or clear (empty run).
          if (r_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign layer_idx = r_layer_idx;
  assign buf_sel   = r_buf_sel;
  assign acc_start = r_acc_start;

endmodule
